// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback stage and a long-latency unit (multi-cycle mul/div, slow load
// return). Long-latency results are queued in a small in-order FIFO.
//
// The pipeline normally has priority. The FIFO head is forced onto the port,
// with the pipeline stalled, in either of two cases:
// - the FIFO is full;
// - the head has waited MAX_WAIT cycles.
// When the pipeline has nothing to write, the FIFO head drains for free.
//
// Optional build macro: WB_ARB_STATS_EN
//   When defined, stall_cnt counts cycles with stall_pipe=1, saturating at
//   16'hFFFF. When undefined, stall_cnt is tied to zero.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   pipe_wr_en, pipe_rd, pipe_data  WB stage write request
//   stall_pipe                      pipeline must hold its WB inputs this cycle
//   ll_valid, ll_rd, ll_data        long-latency result offered
//   ll_ready                        arbiter accepts the long-latency result
//   rf_wr_en, rf_rd, rf_data        register-file write port
//   stall_cnt                       stall-cycle statistics counter
module wb_port_arbiter #(
  parameter int N        = 32,
  parameter int RW       = 6,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pipe_wr_en,
  input  logic [RW-1:0] pipe_rd,
  input  logic [N-1:0]  pipe_data,
  output logic          stall_pipe,
  input  logic          ll_valid,
  output logic          ll_ready,
  input  logic [RW-1:0] ll_rd,
  input  logic [N-1:0]  ll_data,
  output logic          rf_wr_en,
  output logic [RW-1:0] rf_rd,
  output logic [N-1:0]  rf_data,
  output logic [15:0]   stall_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int AGEW = $clog2(MAX_WAIT + 1);
  localparam int EW   = RW + N;
  localparam logic [AGEW-1:0] AGE_MAX = AGEW'(MAX_WAIT);

  // FIFO storage; each entry is {rd, data}
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AGEW-1:0] age_q, age_d;

  logic            empty_s;
  logic            full_s;
  logic            preq_s;
  logic            ll_sel_s;
  logic            push_s;
  logic            pop_s;
  logic [EW-1:0]   head_s;
  logic [RW-1:0]   head_rd_s;
  logic [N-1:0]    head_data_s;

  // FIFO status and grant decision from registered state plus current inputs
  always_comb begin
    empty_s     = (wr_ptr_q == rd_ptr_q);
    full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head_s      = mem_q[rd_ptr_q[AW-1:0]];
    head_rd_s   = head_s[EW-1:N];
    head_data_s = head_s[N-1:0];
    // A write to x0 is not a request at all
    preq_s      = pipe_wr_en && (pipe_rd != {RW{1'b0}});
    ll_sel_s    = !empty_s && (!preq_s || full_s || (age_q == AGE_MAX));
    // No pop-through: a full FIFO refuses new results even while popping
    push_s      = ll_valid && !full_s;
    pop_s       = ll_sel_s;
  end

  // RF port mux; reset forces all outputs quiet without waiting for a clock
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_rd      = pipe_rd;
    rf_data    = pipe_data;
    stall_pipe = 1'b0;
    ll_ready   = !full_s;
    if (!rst_n) begin
      rf_rd    = {RW{1'b0}};
      rf_data  = {N{1'b0}};
      ll_ready = 1'b1;
    end else if (ll_sel_s) begin
      rf_rd      = head_rd_s;
      rf_data    = head_data_s;
      // An rd==0 entry is discarded without touching the RF
      rf_wr_en   = (head_rd_s != {RW{1'b0}});
      stall_pipe = preq_s;
    end else if (preq_s) begin
      rf_wr_en = 1'b1;
    end else begin
      rf_wr_en = 1'b0;
    end
  end

  // Next-state for FIFO contents, pointers and head age
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = {ll_rd, ll_data};
    end else begin
      mem_d[wr_ptr_q[AW-1:0]] = mem_q[wr_ptr_q[AW-1:0]];
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Age tracks how long the current head has been passed over
    if (empty_s || pop_s) begin
      age_d = {AGEW{1'b0}};
    end else if (age_q == AGE_MAX) begin
      age_d = age_q;
    end else begin
      age_d = age_q + AGEW'(1);
    end
  end

  // FIFO and age registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      age_q    <= {AGEW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      age_q    <= age_d;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles
  always_comb begin
    if (stall_pipe && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback stage;
  - a long-latency unit (multi-cycle mul/div, slow load return).
- Long-latency results are buffered in a small FIFO.
- The pipeline has priority; a buffered result is forced through, with the pipeline stalled, when the FIFO fills or an aging limit is hit.
- Sits between the WB stage output and the RF write port.

Parameters:
- N, 32, data width.
- RW, 6, register-destination width.
- DEPTH, 2, long-latency FIFO entries (power of two, >=2).
- MAX_WAIT, 4, maximum cycles a non-empty FIFO head waits before a forced grant (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_wr_en  in  1  WB stage write request.
- pipe_rd  in  RW  WB stage destination register.
- pipe_data  in  N  WB stage write data.
- stall_pipe  out  1  pipeline must hold its WB inputs this cycle.
- ll_valid  in  1  long-latency result valid.
- ll_ready  out  1  arbiter accepts long-latency result.
- ll_rd  in  RW  long-latency destination register.
- ll_data  in  N  long-latency result data.
- rf_wr_en  out  1  RF write enable.
- rf_rd  out  RW  RF write destination.
- rf_data  out  N  RF write data.
- stall_cnt  out  16  stall-cycle counter; zero unless WB_ARB_STATS_EN.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, age=0, stall_cnt=0.
  - Outputs: rf_wr_en=0, stall_pipe=0, ll_ready=1, rf_rd=0, rf_data=0.
- Effective pipeline request: preq = pipe_wr_en && (pipe_rd != 0). A write to x0 is never a request and never causes a stall.
- Long-latency accept:
  - ll_ready = !full, combinational from registered FIFO state.
  - Push on ll_valid && ll_ready.
  - A result accepted in cycle t is written to the RF no earlier than t+1. There is no bypass.
  - FIFO entries with rd==0 are popped without an RF write (rf_wr_en=0 that cycle).
- Grant, combinational each cycle:
  - ll_sel = !empty && (!preq || full || age==MAX_WAIT).
  - If ll_sel: RF port driven from FIFO head, head popped at the clock edge.
    - stall_pipe = preq.
    - rf_wr_en = (head_rd != 0).
  - Else if preq: RF port driven from pipe_rd/pipe_data, rf_wr_en=1, stall_pipe=0.
  - Else: rf_wr_en=0, and rf_rd/rf_data hold the pipe inputs (don't-care to the RF).
- Full with pop in the same cycle: ll_ready is still 0 that cycle (no pop-through). Ready rises the next cycle.
- Age counter:
  - Increments, saturating at MAX_WAIT, each cycle the FIFO is non-empty and the head is not popped.
  - Clears to 0 on every pop, and while the FIFO is empty.
- Ordering:
  - The FIFO is strictly in order.
  - The pipeline must not issue a WB write to a register with an outstanding long-latency op. That is the hazard unit's job; the arbiter does not check it.
- Pointers: FIFO pointers wrap modulo DEPTH. Full/empty use an extra wrap bit.
- Stalled pipeline: holds pipe_* stable. The arbiter makes no assumption beyond re-sampling them each cycle.
- Reset mid-operation: FIFO contents are discarded, and any in-flight stall drops immediately (asynchronous).

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined: stall_cnt increments (saturating at 16'hFFFF) on every cycle with stall_pipe=1. Reset clears it.
- Undefined: stall_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Pipe-only writes:
  - Stimulus: pipe_wr_en=1, rd=5, data=32'hA5A5_0001 for 3 cycles, ll_valid=0.
  - Response: rf_wr_en=1, rf_rd=5, rf_data matches each cycle; stall_pipe=0.
- Idle slot drain:
  - Stimulus: ll push rd=7, data=32'h1234 at cycle t; pipe idle.
  - Response: cycle t+1 has rf_wr_en=1, rf_rd=7, rf_data=32'h1234, stall_pipe=0; FIFO empty at t+2.
- Aging:
  - Stimulus: one ll entry rd=9, pipe writing continuously from t+1, MAX_WAIT=4.
  - Response: pipe owns the port for 4 cycles; the next cycle the FIFO head is written with stall_pipe=1; the pipe write follows one cycle later.
- Full FIFO:
  - Stimulus: DEPTH=2, two ll pushes back-to-back with the pipe writing every cycle.
  - Response: ll_ready=0 after the second push; a forced grant occurs with stall_pipe=1; ll_ready=1 the cycle after the pop.
- x0 handling:
  - Stimulus: pipe rd=0 with wr_en=1 while the FIFO holds an entry; then an ll push with rd=0.
  - Response: FIFO head written, no stall; the rd=0 entry is popped with rf_wr_en=0.
- Async reset:
  - Stimulus: assert rst_n=0 mid-cycle with 2 entries queued and stall_pipe=1.
  - Response: stall_pipe=0, rf_wr_en=0, ll_ready=1 immediately; no writes after release; stall_cnt=0 (STATS build).
